// File: rtl/uart_bus_pkg.sv
// Shared constants for the UART bus front-end: bus selection names and AHB-Lite encodings.
package uart_bus_pkg;

   localparam string BusApb    = "APB";
   localparam string BusAhb    = "AHB";
   localparam string BusAvalon = "AVALON";

   typedef enum logic [1:0] {
      HtransIdle   = 2'b00,
      HtransBusy   = 2'b01,
      HtransNonseq = 2'b10,
      HtransSeq    = 2'b11
   } htrans_e;

   localparam logic HrespOkay = 1'b0;

endpackage

// File: rtl/uart_ahb2sif.sv
// AHB-Lite to register-interface bridge: address phase is registered, access happens in the
// data phase; back-to-back transfers overlap.
module uart_ahb2sif
   import uart_bus_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          hsel,
   input  logic          hwrite,
   input  logic          hready,
   input  logic [1:0]    htrans,
   input  logic [AW-1:0] haddr,
   input  logic [DW-1:0] hwdata,
   output logic [DW-1:0] hrdata,
   output logic          hreadyout,
   output logic          hresp,
   output logic [AW-1:0] sif_addr,
   output logic          sif_we,
   output logic [DW-1:0] sif_wd,
   input  logic [DW-1:0] sif_rd
);

   logic          valid_d, valid_q;
   logic          hwrite_d, hwrite_q;
   logic [AW-1:0] addr_d, addr_q;

   always_comb begin
      valid_d  = hsel & hready & ((htrans == HtransNonseq) || (htrans == HtransSeq));
      addr_d   = valid_d ? haddr : addr_q;
      hwrite_d = valid_d ? hwrite : hwrite_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q  <= 1'b0;
         hwrite_q <= 1'b0;
         addr_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         hwrite_q <= hwrite_d;
         addr_q   <= addr_d;
      end
   end

   // Outside a pending data phase the live address is shown so reads still see a sensible value.
   assign sif_addr  = valid_q ? addr_q : haddr;
   assign sif_we    = valid_q & hwrite_q;
   assign sif_wd    = hwdata;
   assign hrdata    = sif_rd;
   assign hreadyout = 1'b1;
   assign hresp     = HrespOkay;

endmodule

// File: rtl/uart_apb2sif.sv
// APB to register-interface bridge: zero-wait, writes in the access phase, reads combinational.
module uart_apb2sif #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          psel,
   input  logic          penable,
   input  logic          pwrite,
   input  logic [AW-1:0] paddr,
   input  logic [DW-1:0] pwdata,
   output logic [DW-1:0] prdata,
   output logic          pready,
   output logic          pslverr,
   output logic [AW-1:0] sif_addr,
   output logic          sif_we,
   output logic [DW-1:0] sif_wd,
   input  logic [DW-1:0] sif_rd
);

   assign sif_addr = paddr;
   assign sif_wd   = pwdata;
   assign sif_we   = psel & penable & pwrite;
   assign prdata   = sif_rd;
   assign pready   = 1'b1;
   assign pslverr  = 1'b0;

endmodule

// File: rtl/uart_avalon2sif.sv
// Avalon-MM to register-interface bridge: zero-wait writes, fixed read latency of one cycle.
module uart_avalon2sif #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          read,
   input  logic          write,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          waitrequest,
   output logic          readdatavalid,
   output logic [AW-1:0] sif_addr,
   output logic          sif_we,
   output logic [DW-1:0] sif_wd,
   input  logic [DW-1:0] sif_rd
);

   logic          rdv_d, rdv_q;
   logic [DW-1:0] readdata_d, readdata_q;

   // A simultaneous write wins; the read is dropped.
   always_comb begin
      rdv_d      = read & ~write;
      readdata_d = rdv_d ? sif_rd : readdata_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdv_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         rdv_q      <= rdv_d;
         readdata_q <= readdata_d;
      end
   end

   assign sif_addr      = address;
   assign sif_wd        = writedata;
   assign sif_we        = write;
   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;
   assign waitrequest   = 1'b0;

endmodule

// File: rtl/uart_bus_slave.sv
// Selectable bus front-end for the UART register file; one protocol bridge chosen at elaboration.
module uart_bus_slave
   import uart_bus_pkg::*;
#(
   parameter string       BUS_TYPE = "APB",
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          psel,
   input  logic          penable,
   input  logic          pwrite,
   input  logic [AW-1:0] paddr,
   input  logic [DW-1:0] pwdata,
   output logic [DW-1:0] prdata,
   output logic          pready,
   output logic          pslverr,
   input  logic          hsel,
   input  logic          hwrite,
   input  logic          hready,
   input  logic [1:0]    htrans,
   input  logic [2:0]    hsize,
   input  logic [AW-1:0] haddr,
   input  logic [DW-1:0] hwdata,
   output logic [DW-1:0] hrdata,
   output logic          hreadyout,
   output logic          hresp,
   input  logic          read,
   input  logic          write,
   input  logic [AW-1:0] address,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          waitrequest,
   output logic          readdatavalid,
   output logic [AW-1:0] sif_addr,
   output logic          sif_we,
   output logic [DW-1:0] sif_wd,
   input  logic [DW-1:0] sif_rd
);

   // Inputs of unselected protocols (and hsize, all accesses are full-word) are deliberately dropped.
   logic unused_inputs;
   assign unused_inputs = ^{psel, penable, pwrite, paddr, pwdata, hsel, hwrite, hready, htrans,
                            hsize, haddr, hwdata, read, write, address, writedata, clk, rstn};

   if (BUS_TYPE == BusApb) begin : g_apb
      uart_apb2sif #(.AW(AW), .DW(DW)) u_apb (
         .psel     (psel),
         .penable  (penable),
         .pwrite   (pwrite),
         .paddr    (paddr),
         .pwdata   (pwdata),
         .prdata   (prdata),
         .pready   (pready),
         .pslverr  (pslverr),
         .sif_addr (sif_addr),
         .sif_we   (sif_we),
         .sif_wd   (sif_wd),
         .sif_rd   (sif_rd)
      );
      assign hrdata        = '0;
      assign hreadyout     = 1'b0;
      assign hresp         = 1'b0;
      assign readdata      = '0;
      assign waitrequest   = 1'b0;
      assign readdatavalid = 1'b0;
   end else if (BUS_TYPE == BusAhb) begin : g_ahb
      uart_ahb2sif #(.AW(AW), .DW(DW)) u_ahb (
         .clk       (clk),
         .rstn      (rstn),
         .hsel      (hsel),
         .hwrite    (hwrite),
         .hready    (hready),
         .htrans    (htrans),
         .haddr     (haddr),
         .hwdata    (hwdata),
         .hrdata    (hrdata),
         .hreadyout (hreadyout),
         .hresp     (hresp),
         .sif_addr  (sif_addr),
         .sif_we    (sif_we),
         .sif_wd    (sif_wd),
         .sif_rd    (sif_rd)
      );
      assign prdata        = '0;
      assign pready        = 1'b0;
      assign pslverr       = 1'b0;
      assign readdata      = '0;
      assign waitrequest   = 1'b0;
      assign readdatavalid = 1'b0;
   end else if (BUS_TYPE == BusAvalon) begin : g_avalon
      uart_avalon2sif #(.AW(AW), .DW(DW)) u_avalon (
         .clk           (clk),
         .rstn          (rstn),
         .read          (read),
         .write         (write),
         .address       (address),
         .writedata     (writedata),
         .readdata      (readdata),
         .waitrequest   (waitrequest),
         .readdatavalid (readdatavalid),
         .sif_addr      (sif_addr),
         .sif_we        (sif_we),
         .sif_wd        (sif_wd),
         .sif_rd        (sif_rd)
      );
      assign prdata    = '0;
      assign pready    = 1'b0;
      assign pslverr   = 1'b0;
      assign hrdata    = '0;
      assign hreadyout = 1'b0;
      assign hresp     = 1'b0;
   end else begin : g_bad
      $fatal(1, "uart_bus_slave: unsupported BUS_TYPE %s", BUS_TYPE);
   end

endmodule

// File: tb/tb_uart_bus_slave.sv
// Bench for uart_bus_slave: one instance per bus type sharing stimulus, table-driven vectors
// plus a hand-written asynchronous-reset sequence.
module tb_uart_bus_slave;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic          psel, penable, pwrite, hsel, hwrite, hready, av_read, av_write;
   logic [1:0]    htrans;
   logic [2:0]    hsize;
   logic [AW-1:0] paddr, haddr, address;
   logic [DW-1:0] pwdata, hwdata, writedata, sif_rd;

   // Index 0 = APB instance, 1 = AHB instance, 2 = Avalon instance.
   logic [DW-1:0] prdata_w [3];
   logic          pready_w [3];
   logic          pslverr_w [3];
   logic [DW-1:0] hrdata_w [3];
   logic          hreadyout_w [3];
   logic          hresp_w [3];
   logic [DW-1:0] readdata_w [3];
   logic          waitreq_w [3];
   logic          rdv_w [3];
   logic [AW-1:0] sif_addr_w [3];
   logic          sif_we_w [3];
   logic [DW-1:0] sif_wd_w [3];

   uart_bus_slave #(.BUS_TYPE("APB"), .AW(AW), .DW(DW)) u_dut_0 (
      .clk(clk), .rstn(rstn),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]),
      .hsel(hsel), .hwrite(hwrite), .hready(hready), .htrans(htrans), .hsize(hsize),
      .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata_w[0]), .hreadyout(hreadyout_w[0]),
      .hresp(hresp_w[0]), .read(av_read), .write(av_write), .address(address),
      .writedata(writedata), .readdata(readdata_w[0]), .waitrequest(waitreq_w[0]),
      .readdatavalid(rdv_w[0]), .sif_addr(sif_addr_w[0]), .sif_we(sif_we_w[0]),
      .sif_wd(sif_wd_w[0]), .sif_rd(sif_rd));

   uart_bus_slave #(.BUS_TYPE("AHB"), .AW(AW), .DW(DW)) u_dut_1 (
      .clk(clk), .rstn(rstn),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]),
      .hsel(hsel), .hwrite(hwrite), .hready(hready), .htrans(htrans), .hsize(hsize),
      .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata_w[1]), .hreadyout(hreadyout_w[1]),
      .hresp(hresp_w[1]), .read(av_read), .write(av_write), .address(address),
      .writedata(writedata), .readdata(readdata_w[1]), .waitrequest(waitreq_w[1]),
      .readdatavalid(rdv_w[1]), .sif_addr(sif_addr_w[1]), .sif_we(sif_we_w[1]),
      .sif_wd(sif_wd_w[1]), .sif_rd(sif_rd));

   uart_bus_slave #(.BUS_TYPE("AVALON"), .AW(AW), .DW(DW)) u_dut_2 (
      .clk(clk), .rstn(rstn),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]),
      .hsel(hsel), .hwrite(hwrite), .hready(hready), .htrans(htrans), .hsize(hsize),
      .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata_w[2]), .hreadyout(hreadyout_w[2]),
      .hresp(hresp_w[2]), .read(av_read), .write(av_write), .address(address),
      .writedata(writedata), .readdata(readdata_w[2]), .waitrequest(waitreq_w[2]),
      .readdatavalid(rdv_w[2]), .sif_addr(sif_addr_w[2]), .sif_we(sif_we_w[2]),
      .sif_wd(sif_wd_w[2]), .sif_rd(sif_rd));

   typedef struct {
      int          inst;
      logic        psel, penable, pwrite;
      logic [31:0] paddr, pwdata;
      logic        hsel;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [31:0] haddr, hwdata;
      logic        rd, wr;
      logic [31:0] address, writedata, sif_rd;
      logic        exp_we;
      logic [31:0] exp_addr, exp_wd, exp_rdata;
      logic        exp_rdv;
   } vec_t;

   int total = 0;
   int bad   = 0;
   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t blank(input int inst);
      vec_t v;
      v = '{inst: inst, default: '0};
      return v;
   endfunction

   function automatic vec_t apb_v(input logic s, input logic e, input logic w,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rd, input logic xwe,
                                  input logic [31:0] xa, input logic [31:0] xd,
                                  input logic [31:0] xr);
      vec_t v = blank(0);
      v.psel = s; v.penable = e; v.pwrite = w; v.paddr = a; v.pwdata = d; v.sif_rd = rd;
      v.exp_we = xwe; v.exp_addr = xa; v.exp_wd = xd; v.exp_rdata = xr;
      return v;
   endfunction

   function automatic vec_t ahb_v(input logic s, input logic [1:0] t, input logic w,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rd, input logic xwe,
                                  input logic [31:0] xa, input logic [31:0] xd,
                                  input logic [31:0] xr);
      vec_t v = blank(1);
      v.hsel = s; v.htrans = t; v.hwrite = w; v.haddr = a; v.hwdata = d; v.sif_rd = rd;
      v.exp_we = xwe; v.exp_addr = xa; v.exp_wd = xd; v.exp_rdata = xr;
      return v;
   endfunction

   function automatic vec_t avl_v(input logic r, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] rd,
                                  input logic xwe, input logic [31:0] xa,
                                  input logic [31:0] xd, input logic [31:0] xr,
                                  input logic xv);
      vec_t v = blank(2);
      v.rd = r; v.wr = w; v.address = a; v.writedata = d; v.sif_rd = rd;
      v.exp_we = xwe; v.exp_addr = xa; v.exp_wd = xd; v.exp_rdata = xr; v.exp_rdv = xv;
      return v;
   endfunction

   task automatic drive_idle();
      psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      hsel = 0; htrans = 2'b00; hwrite = 0; hready = 1; hsize = 3'd2; haddr = '0; hwdata = '0;
      av_read = 0; av_write = 0; address = '0; writedata = '0; sif_rd = '0;
   endtask

   task automatic apply(input vec_t v);
      psel = v.psel; penable = v.penable; pwrite = v.pwrite; paddr = v.paddr; pwdata = v.pwdata;
      hsel = v.hsel; htrans = v.htrans; hwrite = v.hwrite; haddr = v.haddr; hwdata = v.hwdata;
      av_read = v.rd; av_write = v.wr; address = v.address; writedata = v.writedata;
      sif_rd = v.sif_rd; hready = 1'b1;
   endtask

   initial begin
      // APB write then read
      vecs.push_back(apb_v(0, 0, 0, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h00));
      vecs.push_back(apb_v(1, 0, 1, 32'h04, 32'h55, 32'h00, 0, 32'h04, 32'h55, 32'h00));
      vecs.push_back(apb_v(1, 1, 1, 32'h04, 32'h55, 32'h00, 1, 32'h04, 32'h55, 32'h00));
      vecs.push_back(apb_v(0, 0, 0, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h00));
      vecs.push_back(apb_v(1, 0, 0, 32'h08, 32'h00, 32'hA5, 0, 32'h08, 32'h00, 32'hA5));
      vecs.push_back(apb_v(1, 1, 0, 32'h08, 32'h00, 32'hA5, 0, 32'h08, 32'h00, 32'hA5));
      // AHB back-to-back write/read, IDLE, BUSY, SEQ
      vecs.push_back(ahb_v(1, 2'b10, 1, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h00));
      vecs.push_back(ahb_v(1, 2'b10, 0, 32'h04, 32'h11, 32'h00, 1, 32'h00, 32'h11, 32'h00));
      vecs.push_back(ahb_v(0, 2'b00, 0, 32'h00, 32'h00, 32'h22, 0, 32'h04, 32'h00, 32'h22));
      vecs.push_back(ahb_v(1, 2'b00, 1, 32'h10, 32'h00, 32'h00, 0, 32'h10, 32'h00, 32'h00));
      vecs.push_back(ahb_v(1, 2'b00, 1, 32'h10, 32'h99, 32'h00, 0, 32'h10, 32'h99, 32'h00));
      vecs.push_back(ahb_v(1, 2'b01, 1, 32'h14, 32'h00, 32'h00, 0, 32'h14, 32'h00, 32'h00));
      vecs.push_back(ahb_v(1, 2'b11, 1, 32'h18, 32'h00, 32'h00, 0, 32'h18, 32'h00, 32'h00));
      vecs.push_back(ahb_v(0, 2'b00, 0, 32'h00, 32'h77, 32'h00, 1, 32'h18, 32'h77, 32'h00));
      vecs.push_back(ahb_v(0, 2'b00, 0, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h00));
      // Avalon read latency, write, read+write collision
      vecs.push_back(avl_v(1, 0, 32'h0C, 32'h00, 32'h3C, 0, 32'h0C, 32'h00, 32'h00, 0));
      vecs.push_back(avl_v(0, 0, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h3C, 1));
      vecs.push_back(avl_v(0, 0, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h3C, 0));
      vecs.push_back(avl_v(0, 1, 32'h20, 32'hAB, 32'h00, 1, 32'h20, 32'hAB, 32'h3C, 0));
      vecs.push_back(avl_v(1, 1, 32'h24, 32'hCD, 32'hEE, 1, 32'h24, 32'hCD, 32'h3C, 0));
      vecs.push_back(avl_v(0, 0, 32'h00, 32'h00, 32'h00, 0, 32'h00, 32'h00, 32'h3C, 0));

      drive_idle();
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset ahb sif_we", 32'(sif_we_w[1]), 32'h0);
      chk("reset avl readdata", readdata_w[2], 32'h0);
      chk("reset avl readdatavalid", 32'(rdv_w[2]), 32'h0);
      chk("reset avl sif_we", 32'(sif_we_w[2]), 32'h0);
      chk("reset apb sif_addr", sif_addr_w[0], 32'h0);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         int k;
         logic [31:0] rdata;
         @(negedge clk);
         apply(vecs[i]);
         #1;
         k = vecs[i].inst;
         rdata = (k == 0) ? prdata_w[0] : (k == 1) ? hrdata_w[1] : readdata_w[2];
         chk($sformatf("v%0d sif_we", i), 32'(sif_we_w[k]), 32'(vecs[i].exp_we));
         chk($sformatf("v%0d sif_addr", i), sif_addr_w[k], vecs[i].exp_addr);
         chk($sformatf("v%0d sif_wd", i), sif_wd_w[k], vecs[i].exp_wd);
         chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
         if (k == 2) chk($sformatf("v%0d readdatavalid", i), 32'(rdv_w[2]), 32'(vecs[i].exp_rdv));
         chk($sformatf("v%0d pready", i), 32'(pready_w[0]), 32'h1);
         chk($sformatf("v%0d pslverr", i), 32'(pslverr_w[0]), 32'h0);
         chk($sformatf("v%0d hreadyout", i), 32'(hreadyout_w[1]), 32'h1);
         chk($sformatf("v%0d hresp", i), 32'(hresp_w[1]), 32'h0);
         chk($sformatf("v%0d waitrequest", i), 32'(waitreq_w[2]), 32'h0);
         chk($sformatf("v%0d apb tie hreadyout", i), 32'(hreadyout_w[0]), 32'h0);
         chk($sformatf("v%0d ahb tie pready", i), 32'(pready_w[1]), 32'h0);
      end

      // Asynchronous reset during an AHB data phase and a pending Avalon read
      @(negedge clk);
      drive_idle();
      hsel = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h30;
      av_read = 1; address = 32'h40; sif_rd = 32'h12;
      @(negedge clk);
      drive_idle();
      hwdata = 32'h5A;
      #1;
      chk("pre-reset ahb sif_we", 32'(sif_we_w[1]), 32'h1);
      chk("pre-reset ahb sif_addr", sif_addr_w[1], 32'h30);
      chk("pre-reset avl readdatavalid", 32'(rdv_w[2]), 32'h1);
      rstn = 1'b0;
      #1;
      chk("async reset ahb sif_we", 32'(sif_we_w[1]), 32'h0);
      chk("async reset avl readdatavalid", 32'(rdv_w[2]), 32'h0);
      chk("async reset avl readdata", readdata_w[2], 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("post-reset c%0d ahb sif_we", c), 32'(sif_we_w[1]), 32'h0);
         chk($sformatf("post-reset c%0d avl readdatavalid", c), 32'(rdv_w[2]), 32'h0);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
